serial_seq_gen: RTL and testbench
=================================

Name: serial_seq_gen

Overview:
Moore-style serial bit-stream generator, the transmit side for the lab's Moore sequence detectors. It loads a parallel pattern and shifts it out MSB-first on a single serial line, repeating it a programmable number of times. It drives the detectors' serial x_in input in loopback benches and on-board demos. All outputs are functions of registered state only (pure Moore).

Parameters:
WIDTH, 8, pattern length in bits (>=2)
REP_W, 4, width of repeat-count input

Ports:
clk      input   1        system clock, rising edge
rst      input   1        asynchronous reset, active-high
start    input   1        request to begin; sampled only in IDLE
pattern  input   WIDTH    pattern to transmit, latched on accepted start
reps     input   REP_W    number of back-to-back pattern repetitions, latched on accepted start
abort    input   1        terminate transmission; sampled only in SEND
x_out    output  1        serial data, MSB of pattern first
x_valid  output  1        high on every cycle x_out carries a pattern bit
busy     output  1        high in SEND and DONE
done     output  1        one-cycle completion pulse
state    output  2        current state code, for debug/LED display

Behaviour:
- States: IDLE=2'b00, SEND=2'b01, DONE=2'b10; 2'b11 unused and recovers to IDLE on the next edge.
- Reset (async, any time, including mid-SEND): state=IDLE, shift register=0, bit counter=0, repeat counter=0. Outputs go immediately to x_out=0, x_valid=0, busy=0, done=0, state=2'b00.
- IDLE: all outputs 0. On an edge with start=1:
  - reps!=0: latch pattern into shift reg, latch reps into repeat counter, set bit counter=WIDTH-1, go to SEND.
  - reps==0: go to DONE and send no bits.
- SEND: x_out=shreg[WIDTH-1], x_valid=1, busy=1. Each edge shifts shreg left by 1 and decrements the bit counter.
  - At bit counter=0: if repeat counter>1, decrement it, reload shreg from the latched pattern copy and set bit counter=WIDTH-1. There is no idle gap between repetitions.
  - At bit counter=0 with repeat counter==1: go to DONE.
- Latency: start accepted at edge k gives first bit pattern[WIDTH-1] valid from edge k to edge k+1. Valid cycles total exactly WIDTH*reps, contiguous.
- DONE: done=1, busy=1, x_valid=0, x_out=0 for exactly one cycle, then IDLE. start is ignored in DONE.
- start while in SEND or DONE is ignored. Changes to pattern/reps after acceptance have no effect until the next accepted start.
- abort=1 on an edge in SEND: go to IDLE, no done pulse, counters cleared. abort has priority over last-bit completion on the same edge. abort in IDLE/DONE is ignored.
- start and abort both high in IDLE: start is accepted.
- Repeat counter uses unsigned REP_W bits. Max reps=2^REP_W-1 with no wrap.

Test Plan:
- Reset asserted at t=0, released at 1 ns with start=0 -> state=00, x_out=0, x_valid=0, busy=0, done=0 for 5 cycles.
- pattern=8'b1011_0001, reps=1, 1-cycle start pulse -> x_out=1,0,1,1,0,0,0,1 on 8 consecutive valid cycles. done=1 on cycle 9. busy high for 9 cycles. Back in IDLE on cycle 10.
- pattern=8'hA5, reps=3 -> 24 contiguous valid cycles, sequence 10100101 repeated 3x with no gap, then a single done pulse.
- reps=0 with start -> DONE for one cycle (done=1, x_valid never 1), then IDLE.
- During SEND with pattern=8'hF0, drive start=1 and pattern=8'h0F at bit 3 -> output stays 11110000 and no restart. Then abort=1 at bit 5 -> IDLE next cycle, done never pulses.
- rst asserted asynchronously mid-SEND (between edges) -> x_valid/busy drop to 0 immediately. After release, a new start transmits correctly. Loopback into the team's Moore detector with a pattern containing its target sequence -> detector reaches its accept state at the expected cycle.

Source files
------------

// File: rtl/serial_seq_gen.sv
// Serial bit-stream generator: loads a parallel pattern on start and shifts it out
// MSB-first, repeating it back-to-back a programmable number of times. Pure Moore:
// every output is a flop, so all outputs depend on registered state only.
module serial_seq_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  output logic             x_out,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StSend = 2'b01,
    StDone = 2'b10,
    StBad  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pat_q, pat_d;    // latched copy used to reload between repetitions
  logic [CntW-1:0]  bitcnt_q, bitcnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             x_out_q, x_valid_q, busy_q, done_q;
  logic             x_out_d, x_valid_d, busy_d, done_d;

  // Next-state and datapath update; outputs are derived from the next state so they
  // can be registered and still line up with the state they describe.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    pat_d    = pat_q;
    bitcnt_d = bitcnt_q;
    rep_d    = rep_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (reps != '0) begin
            state_d  = StSend;
            shreg_d  = pattern;
            pat_d    = pattern;
            bitcnt_d = LastIdx;
            rep_d    = reps;
          end else begin
            state_d = StDone;
          end
        end
      end
      StSend: begin
        // abort wins over last-bit completion on the same edge
        if (abort) begin
          state_d  = StIdle;
          shreg_d  = '0;
          bitcnt_d = '0;
          rep_d    = '0;
        end else if (bitcnt_q == '0) begin
          if (rep_q > REP_W'(1)) begin
            rep_d    = rep_q - REP_W'(1);
            shreg_d  = pat_q;
            bitcnt_d = LastIdx;
          end else begin
            state_d = StDone;
            shreg_d = '0;
            rep_d   = '0;
          end
        end else begin
          shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
          bitcnt_d = bitcnt_q - CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d  = StIdle;
        shreg_d  = '0;
        bitcnt_d = '0;
        rep_d    = '0;
      end
    endcase

    x_valid_d = (state_d == StSend);
    x_out_d   = (state_d == StSend) & shreg_d[WIDTH-1];
    busy_d    = (state_d == StSend) || (state_d == StDone);
    done_d    = (state_d == StDone);
  end

  // State, datapath and registered outputs; async reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      pat_q     <= '0;
      bitcnt_q  <= '0;
      rep_q     <= '0;
      x_out_q   <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      pat_q     <= pat_d;
      bitcnt_q  <= bitcnt_d;
      rep_q     <= rep_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x_out   = x_out_q;
  assign x_valid = x_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign state   = state_q;

endmodule

// File: tb/tb_serial_seq_gen.sv
// Self-checking bench for serial_seq_gen: directed and random transmissions compared
// against an expected bit queue built from the pattern and repeat count.
module tb_serial_seq_gen;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned REP_W = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [REP_W-1:0] reps;
  logic             abort;
  logic             x_out;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  // {state, busy, done, x_valid, x_out}
  logic [5:0] obs;
  assign obs = {state, busy, done, x_valid, x_out};

  int checks;
  int failures;

  serial_seq_gen #(
    .WIDTH(WIDTH),
    .REP_W(REP_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pattern(pattern),
    .reps   (reps),
    .abort  (abort),
    .x_out  (x_out),
    .x_valid(x_valid),
    .busy   (busy),
    .done   (done),
    .state  (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One transmission: abort_at is the bit index during which abort is held (-1 = none);
  // noisy drives start=1 and garbage pattern/reps while busy, which must be ignored.
  task automatic run_tx(input string name, input logic [WIDTH-1:0] pat,
                        input logic [REP_W-1:0] r, input int abort_at, input bit noisy);
    bit         exp_bits[$];
    logic [5:0] exp;
    @(negedge clk);
    start   = 1'b1;
    pattern = pat;
    reps    = r;
    abort   = noisy;  // start wins over abort in IDLE
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    for (int k = 0; k < int'(r); k++)
      for (int b = WIDTH - 1; b >= 0; b--) exp_bits.push_back(pat[b]);
    for (int i = 0; i < exp_bits.size(); i++) begin
      if (noisy) begin
        start   = 1'b1;
        pattern = WIDTH'($urandom);
        reps    = REP_W'($urandom);
      end
      abort = (i == abort_at);
      exp = {2'b01, 1'b1, 1'b0, 1'b1, exp_bits[i]};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s bit%0d obs=%b exp=%b", name, i, obs, exp);
      end
      @(posedge clk);
      #1;
      if (i == abort_at) begin
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if (obs !== 6'b000000) begin
          failures++;
          $display("FAIL %s after_abort obs=%b exp=%b", name, obs, 6'b000000);
        end
        return;
      end
    end
    start = 1'b0;
    abort = noisy;  // ignored in DONE
    exp = {2'b10, 1'b1, 1'b1, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s done_cycle obs=%b exp=%b", name, obs, exp);
    end
    @(posedge clk);
    #1;
    abort = 1'b0;
    checks++;
    if (obs !== 6'b000000) begin
      failures++;
      $display("FAIL %s back_idle obs=%b exp=%b", name, obs, 6'b000000);
    end
  endtask

  task automatic test_reset();
    #0.5;
    checks++;
    if (obs !== 6'b000000) begin
      failures++;
      $display("FAIL reset_during obs=%b exp=%b", obs, 6'b000000);
    end
    #0.5;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (obs !== 6'b000000) begin
        failures++;
        $display("FAIL reset_idle cyc%0d obs=%b exp=%b", i, obs, 6'b000000);
      end
    end
  endtask

  task automatic test_basic();
    run_tx("basic", 8'b1011_0001, 4'd1, -1, 1'b0);
  endtask

  task automatic test_repeat();
    run_tx("repeat3", 8'hA5, 4'd3, -1, 1'b0);
    run_tx("repeat_max", WIDTH'($urandom), 4'd15, -1, 1'b0);
  endtask

  task automatic test_zero_reps();
    run_tx("zero_reps", 8'hFF, 4'd0, -1, 1'b0);
  endtask

  task automatic test_ignore_abort();
    run_tx("ignore_then_abort", 8'hF0, 4'd1, 5, 1'b1);
    run_tx("abort_last_bit", 8'h81, 4'd2, 15, 1'b0);
    run_tx("abort_first_bit", 8'hC3, 4'd4, 0, 1'b0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start   = 1'b1;
    pattern = 8'hFF;
    reps    = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 6'b000000) begin
      failures++;
      $display("FAIL async_reset obs=%b exp=%b", obs, 6'b000000);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (obs !== 6'b000000) begin
      failures++;
      $display("FAIL async_reset_idle obs=%b exp=%b", obs, 6'b000000);
    end
    run_tx("after_reset", 8'h3C, 4'd2, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_tx("b2b_a", 8'h5A, 4'd2, -1, 1'b0);
    run_tx("b2b_b", 8'h96, 4'd1, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [REP_W-1:0] r;
      int ab;
      r  = REP_W'($urandom_range(0, 6));
      ab = ($urandom_range(0, 3) == 0 && r != 0) ? int'($urandom_range(0, WIDTH * r - 1)) : -1;
      run_tx("random", WIDTH'($urandom), r, ab, 1'($urandom));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    pattern  = '0;
    reps     = '0;
    abort    = 1'b0;
    test_reset();
    test_basic();
    test_repeat();
    test_zero_reps();
    test_ignore_abort();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
